// File: rtl/bsg_link_sdr_reset_seq_pkg.sv
// Shared types for the SDR link reset sequencer: FSM state encoding and the
// per-state drive of the four async reset nets plus done.
package bsg_link_sdr_reset_seq_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_token_hi,
    e_token_lo,
    e_up_rel,
    e_down_rel,
    e_ds_rel,
    e_done
  } seq_state_e;

  // {uplink, downlink, downstream, token, done}, indexed by state; slot 7 is unreachable
  localparam logic [7:0][4:0] seq_out_lp = {
    5'b11100,  // unused encoding, parks at the idle drive
    5'b00001,  // e_done
    5'b00000,  // e_ds_rel
    5'b00100,  // e_down_rel
    5'b01100,  // e_up_rel
    5'b11100,  // e_token_lo
    5'b11110,  // e_token_hi
    5'b11100   // e_idle
  };

endpackage

// File: rtl/bsg_link_sdr_reset_phase_counter.sv
// Dwell counter for one sequencer phase; flags the last cycle of the dwell.
module bsg_link_sdr_reset_phase_counter #(
  parameter int unsigned width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic [width_p-1:0] dwell_i,
  output logic [width_p-1:0] count_o,
  output logic               last_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   count_o <= '0;
    else if (clear_i) count_o <= '0;
    else if (up_i)    count_o <= count_o + 1'b1;
  end

  assign last_o = (count_o == (dwell_i - 1'b1));

endmodule

// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Glitch-free bring-up sequencer for the four async reset nets of an SDR link
// endpoint: token pulse, then uplink, downlink and downstream release.
module bsg_link_sdr_reset_sequencer
  import bsg_link_sdr_reset_seq_pkg::*;
#(
  parameter int unsigned token_hi_cycles_p = 16,
  parameter int unsigned token_lo_cycles_p = 16,
  parameter int unsigned release_cycles_p  = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  input  logic restart_i,
  output logic async_uplink_reset_o,
  output logic async_downlink_reset_o,
  output logic async_downstream_reset_o,
  output logic async_token_reset_o,
  output logic done_o
);

  localparam int unsigned max_a_lp   = (token_hi_cycles_p > token_lo_cycles_p)
                                       ? token_hi_cycles_p : token_lo_cycles_p;
  localparam int unsigned max_lp     = (max_a_lp > release_cycles_p) ? max_a_lp : release_cycles_p;
  localparam int unsigned lg_wait_lp = $clog2(max_lp + 1);

  seq_state_e            state_r, state_n;
  logic [lg_wait_lp-1:0] dwell, count;
  logic                  last;
  logic [4:0]            out_r;

  always_comb begin
    dwell = lg_wait_lp'(release_cycles_p);
    case (state_r)
      e_token_hi: dwell = lg_wait_lp'(token_hi_cycles_p);
      e_token_lo: dwell = lg_wait_lp'(token_lo_cycles_p);
      default:    dwell = lg_wait_lp'(release_cycles_p);
    endcase
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:     if (start_i) state_n = e_token_hi;
      e_token_hi: if (last)    state_n = e_token_lo;
      e_token_lo: if (last)    state_n = e_up_rel;
      e_up_rel:   if (last)    state_n = e_down_rel;
      e_down_rel: if (last)    state_n = e_ds_rel;
      e_ds_rel:   if (last)    state_n = e_done;
      e_done:                  state_n = e_done;
      default:                 state_n = e_idle;
    endcase
    // restart wins over everything, and also masks start_i while in idle
    if (restart_i) state_n = e_idle;
  end

  bsg_link_sdr_reset_phase_counter #(
    .width_p(lg_wait_lp)
  ) phase_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (state_n != state_r),
    .up_i     ((state_r != e_idle) && (state_r != e_done)),
    .dwell_i  (dwell),
    .count_o  (count),
    .last_o   (last)
  );

  // outputs load from the next-state decode so each net is a clean flop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      out_r   <= seq_out_lp[e_idle];
    end else begin
      state_r <= state_n;
      out_r   <= seq_out_lp[state_n];
    end
  end

  assign async_uplink_reset_o     = out_r[4];
  assign async_downlink_reset_o   = out_r[3];
  assign async_downstream_reset_o = out_r[2];
  assign async_token_reset_o      = out_r[1];
  assign done_o                   = out_r[0];

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Scoreboard bench for the SDR link reset sequencer: default and all-ones dwell instances.
module tb_bsg_link_sdr_reset_sequencer;

  localparam logic [4:0] idle_v = 5'b11100;

  typedef struct {
    int unsigned e;
    bit          sel;
    logic [4:0]  v;
  } exp_t;

  logic clk, rst_n;
  logic start0, restart0, start1, restart1;
  logic u0, d0, s0, t0, dn0;
  logic u1, d1, s1, t1, dn1;

  int unsigned ecount = 0;
  int unsigned rst_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t q[$];

  bsg_link_sdr_reset_sequencer dut (
    .clk_i                   (clk),
    .reset_n_i               (rst_n),
    .start_i                 (start0),
    .restart_i               (restart0),
    .async_uplink_reset_o    (u0),
    .async_downlink_reset_o  (d0),
    .async_downstream_reset_o(s0),
    .async_token_reset_o     (t0),
    .done_o                  (dn0)
  );

  bsg_link_sdr_reset_sequencer #(
    .token_hi_cycles_p(1),
    .token_lo_cycles_p(1),
    .release_cycles_p (1)
  ) dut1 (
    .clk_i                   (clk),
    .reset_n_i               (rst_n),
    .start_i                 (start1),
    .restart_i               (restart1),
    .async_uplink_reset_o    (u1),
    .async_downlink_reset_o  (d1),
    .async_downstream_reset_o(s1),
    .async_token_reset_o     (t1),
    .done_o                  (dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;
  always @(negedge rst_n) rst_cnt = rst_cnt + 1;

  // Expected drive n cycles after start was sampled, from the release timeline formulas
  function automatic logic [4:0] exp_vec(int n, int w1, int w2, int w3);
    logic [4:0] v;
    v[4] = (n < w1 + w2 + 1);
    v[3] = (n < w1 + w2 + w3 + 1);
    v[2] = (n < w1 + w2 + 2 * w3 + 1);
    v[1] = (n >= 1) && (n <= w1);
    v[0] = (n >= w1 + w2 + 3 * w3 + 1);
    return v;
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic push_tl(bit sel, int unsigned e0, int w1, int w2, int w3, int n_last);
    for (int n = 1; n <= n_last; n++) begin
      exp_t x;
      x.e = e0 + n - 1; x.sel = sel; x.v = exp_vec(n, w1, w2, w3);
      q.push_back(x);
    end
  endtask

  task automatic push_const(bit sel, int unsigned e, int cnt, logic [4:0] v);
    for (int i = 0; i < cnt; i++) begin
      exp_t x;
      x.e = e + i; x.sel = sel; x.v = v;
      q.push_back(x);
    end
  endtask

  // Monitor: compare scheduled expectations and the one-release-per-edge rule
  logic [4:0] prev0 = '0, prev1 = '0;
  int unsigned last_rst_cnt = 0;
  always @(negedge clk) begin
    logic [4:0] c0, c1;
    exp_t x;
    c0 = {u0, d0, s0, t0, dn0};
    c1 = {u1, d1, s1, t1, dn1};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].e <= ecount) begin
        x = q[i];
        q.delete(i);
        if (x.e < ecount) begin
          n_checks++;
          $display("FAIL sb_late: entry for edge %0d seen at edge %0d", x.e, ecount);
        end else if (x.sel) check("seq_p1", c1, x.v);
        else check("seq_def", c0, x.v);
      end
    end
    if (rst_n && rst_cnt == last_rst_cnt) begin
      if ((c0 ^ prev0) != 0 && ((~prev0 & c0 & 5'b11100) == 0)) begin
        n_checks++;
        if ($countones((c0 ^ prev0) & 5'b11110) > 1)
          $display("FAIL one_toggle_def: got %b after %b, required at most one net change", c0, prev0);
        else n_pass++;
      end
      if ((c1 ^ prev1) != 0 && ((~prev1 & c1 & 5'b11100) == 0)) begin
        n_checks++;
        if ($countones((c1 ^ prev1) & 5'b11110) > 1)
          $display("FAIL one_toggle_p1: got %b after %b, required at most one net change", c1, prev1);
        else n_pass++;
      end
    end
    prev0 = c0;
    prev1 = c1;
    last_rst_cnt = rst_cnt;
  end

  initial begin
    int unsigned e0;
    int guard;
    rst_n = 1'b1; start0 = 1'b0; restart0 = 1'b0; start1 = 1'b0; restart1 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_async_def", {u0, d0, s0, t0, dn0}, idle_v);
    check("rst_async_p1", {u1, d1, s1, t1, dn1}, idle_v);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    push_const(0, ecount + 1, 2, idle_v);
    push_const(1, ecount + 1, 2, idle_v);
    repeat (2) @(negedge clk);

    // full default timeline plus all-ones timeline; extra start during token_lo
    start0 = 1'b1; start1 = 1'b1; e0 = ecount + 1;
    push_tl(0, e0, 16, 16, 16, 90);
    push_tl(1, e0, 1, 1, 1, 10);
    @(negedge clk); start0 = 1'b0; start1 = 1'b0;
    repeat (19) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (69) @(negedge clk);

    // restart and start together in done: idle, no token pulse
    restart0 = 1'b1; start0 = 1'b1;
    push_const(0, ecount + 1, 5, idle_v);
    repeat (3) @(negedge clk);
    restart0 = 1'b0; start0 = 1'b0;
    repeat (2) @(negedge clk);

    // restart at cycle 40 (uplink release), then immediate start
    start0 = 1'b1; e0 = ecount + 1;
    push_tl(0, e0, 16, 16, 16, 40);
    @(negedge clk); start0 = 1'b0;
    repeat (39) @(negedge clk);
    restart0 = 1'b1;
    push_const(0, ecount + 1, 1, idle_v);
    @(negedge clk); restart0 = 1'b0; start0 = 1'b1; e0 = ecount + 1;
    push_tl(0, e0, 16, 16, 16, 55);
    @(negedge clk); start0 = 1'b0;
    repeat (54) @(negedge clk);

    // async reset mid-period during downlink release
    #2 rst_n = 1'b0;
    #2;
    check("rst_mid_def", {u0, d0, s0, t0, dn0}, idle_v);
    check("rst_mid_p1", {u1, d1, s1, t1, dn1}, idle_v);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start0 = 1'b1; e0 = ecount + 1;
    push_tl(0, e0, 16, 16, 16, 90);
    @(negedge clk); start0 = 1'b0;
    repeat (89) @(negedge clk);
    @(negedge clk);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    while (q.size() > 0) begin
      n_checks++;
      $display("FAIL sb_timeout: entry for edge %0d never compared", q[0].e);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
